// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifb_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 64;
  localparam int unsigned BUS_TAG_WIDTH  = 13;
  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned LINE_BEATS     = 512 / BUS_DATA_WIDTH;
  localparam int unsigned LINE_SLOTS     = 512 / INSTR_WIDTH;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [BUS_TAG_WIDTH-1:0] IFB_REQ_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'b0};

  typedef enum logic [2:0] {LOAD, REQ, RECV, DRAIN, FLUSH} ifb_state_e;

endpackage

// File: rtl/ifb_line_store.sv
// One cache line of storage: written per bus beat, read per 32-bit slot.
module ifb_line_store
  import ifb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [2:0]                widx_i,
  input  logic [BUS_DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]                slot_i,
  output logic [INSTR_WIDTH-1:0]    rdata_o
);

  logic [BUS_DATA_WIDTH-1:0] line_q [LINE_BEATS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '{default: '0};
    end else if (we_i) begin
      line_q[widx_i] <= wdata_i;
    end
  end

  // Odd slots live in the upper half of a beat.
  always_comb begin
    rdata_o = slot_i[0] ? line_q[slot_i[3:1]][INSTR_WIDTH +: INSTR_WIDTH]
                        : line_q[slot_i[3:1]][0 +: INSTR_WIDTH];
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: reads 64-byte lines from the sysbus and streams 32-bit instructions to decode.
// Optional zero-word halt detection is enabled by defining IFB_HALT_DETECT_EN.
module instr_fetch_buffer
  import ifb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_WIDTH-1:0]    out_instr,
  output logic [63:0]               out_pc,
  output logic                      halted
);

  ifb_state_e       state_q;
  logic [63:0]      pc_q;
  logic [57:0]      req_line_q;
  logic [2:0]       beat_cnt_q;
  logic [3:0]       slot_q;
  logic             redirect_pend_q;
  logic             halted_q;

  logic [63:0]            redir_pc_d;
  logic [57:0]            next_line_d;
  logic [INSTR_WIDTH-1:0] slot_word;
  logic                   beat_d, last_beat_d, word_zero, valid_d, fire_d;
  logic                   unused_bits;

  assign redir_pc_d  = {redirect_pc[63:2], 2'b00};
  assign next_line_d = pc_q[63:6] + 58'd1;
  assign beat_d      = bus_respcyc && ((state_q == RECV) || (state_q == FLUSH));
  assign last_beat_d = beat_d && (beat_cnt_q == 3'd7);
  assign unused_bits = ^{bus_resptag, redirect_pc[1:0]};

`ifdef IFB_HALT_DETECT_EN
  assign word_zero = (slot_word == '0);
  assign halted    = halted_q;
`else
  assign word_zero = 1'b0;
  assign halted    = 1'b0;
`endif

  assign valid_d = (state_q == DRAIN) && !word_zero && !halted_q;
  assign fire_d  = valid_d && out_ready;

  ifb_line_store u_line (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (beat_d && (state_q == RECV)),
    .widx_i  (beat_cnt_q),
    .wdata_i (bus_resp),
    .slot_i  (slot_q),
    .rdata_o (slot_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= LOAD;
      pc_q            <= '0;
      req_line_q      <= '0;
      beat_cnt_q      <= '0;
      slot_q          <= '0;
      redirect_pend_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          pc_q       <= entry;
          req_line_q <= entry[63:6];
          state_q    <= REQ;
        end
        REQ: begin
          if (redirect_valid) pc_q <= redir_pc_d;
          if (bus_reqack) begin
            beat_cnt_q      <= '0;
            redirect_pend_q <= 1'b0;
            state_q         <= (redirect_pend_q || redirect_valid) ? FLUSH : RECV;
          end else if (redirect_valid) begin
            redirect_pend_q <= 1'b1;
          end
        end
        RECV: begin
          if (beat_d) beat_cnt_q <= beat_cnt_q + 3'd1;
          // A redirect on the final beat has nothing left to flush.
          if (redirect_valid) begin
            pc_q <= redir_pc_d;
            if (last_beat_d) begin
              req_line_q <= redir_pc_d[63:6];
              state_q    <= REQ;
            end else begin
              state_q <= FLUSH;
            end
          end else if (last_beat_d) begin
            slot_q  <= pc_q[5:2];
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc_q       <= redir_pc_d;
            req_line_q <= redir_pc_d[63:6];
            halted_q   <= 1'b0;
            state_q    <= REQ;
          end else if (fire_d) begin
            slot_q <= slot_q + 4'd1;
            if (slot_q == 4'hF) begin
              pc_q       <= {next_line_d, 6'b0};
              req_line_q <= next_line_d;
              state_q    <= REQ;
            end
          end else if (word_zero) begin
            halted_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (beat_d) beat_cnt_q <= beat_cnt_q + 3'd1;
          if (redirect_valid) pc_q <= redir_pc_d;
          if (last_beat_d) begin
            req_line_q <= redirect_valid ? redir_pc_d[63:6] : pc_q[63:6];
            state_q    <= REQ;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? {req_line_q, 6'b0} : '0;
  assign bus_reqtag  = IFB_REQ_TAG;
  assign bus_respack = beat_d;
  assign out_valid   = valid_d;
  assign out_instr   = valid_d ? slot_word : '0;
  assign out_pc      = valid_d ? {pc_q[63:6], slot_q, 2'b00} : '0;

endmodule
